// File: rtl/apb_bridge_nslv_if.sv
// CPU-request and APB-bus signal bundle for the N-slave APB bridge.
// master = bridge view, slave = environment view (CPU plus APB slaves).
interface apb_bridge_nslv_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    logic                        transfer;
    logic                        write;
    logic [ADDR_W-1:0]           addr;
    logic [DATA_W-1:0]           wdata;
    logic [DATA_W/8-1:0]         strb;
    logic [DATA_W-1:0]           rdata;
    logic                        ready;
    logic                        error;

    logic [ADDR_W-1:0]           PADDR;
    logic                        PWRITE;
    logic [DATA_W-1:0]           PWDATA;
    logic [DATA_W/8-1:0]         PSTRB;
    logic                        PENABLE;
    logic [NUM_SLV-1:0]          PSEL;
    logic [NUM_SLV*DATA_W-1:0]   PRDATA;
    logic [NUM_SLV-1:0]          PREADY;
    logic [NUM_SLV-1:0]          PSLVERR;

    modport master (
        input  transfer, write, addr, wdata, strb, PRDATA, PREADY, PSLVERR,
        output rdata, ready, error, PADDR, PWRITE, PWDATA, PSTRB, PENABLE, PSEL
    );

    modport slave (
        output transfer, write, addr, wdata, strb, PRDATA, PREADY, PSLVERR,
        input  rdata, ready, error, PADDR, PWRITE, PWDATA, PSTRB, PENABLE, PSEL
    );
endinterface

// File: rtl/apb_bridge_nslv.sv
// Single-request CPU to APB bridge with fixed address decode over up to 16 slaves,
// per-transfer ACCESS timeout and registered one-cycle completion pulse.
//
// state  | meaning
// IDLE   | waiting for transfer; ready pulse of previous access may be visible
// SETUP  | PSEL asserted, PENABLE low, request latched
// ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
// DERR   | decode miss, one cycle, no slave selected
module apb_bridge_nslv #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_bridge_nslv_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                error_q, error_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                dec_hit;
    logic                pready_sel;
    logic                pslverr_sel;
    logic [DATA_W-1:0]   prdata_sel;
    logic [NUM_SLV-1:0]  psel;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
            rdata_q  <= rdata_d;
        end
    end

    // Slave-side mux and select are driven purely from the latched index.
    always_comb begin
        dec_hit = (bus.addr[31:16] == 16'h1000) &&
                  ({1'b0, bus.addr[15:12]} < 5'(NUM_SLV));
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        prdata_sel  = '0;
        psel        = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == 4'(i)) begin
                pready_sel  = bus.PREADY[i];
                pslverr_sel = bus.PSLVERR[i];
                prdata_sel  = bus.PRDATA[i*DATA_W +: DATA_W];
                if ((state_q == SETUP) || (state_q == ACCESS)) begin
                    psel[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        cnt_d    = cnt_q;
        ready_d  = 1'b0;
        error_d  = 1'b0;
        rdata_d  = '0;
        case (state_q)
            IDLE: begin
                if (bus.transfer) begin
                    if (dec_hit) begin
                        idx_d    = bus.addr[15:12];
                        paddr_d  = bus.addr;
                        pwrite_d = bus.write;
                        pwdata_d = bus.wdata;
                        pstrb_d  = bus.write ? bus.strb : '0;
                        state_d  = SETUP;
                    end else begin
                        state_d  = DERR;
                    end
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (pready_sel) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    error_d = pslverr_sel;
                    rdata_d = (!pwrite_q && !pslverr_sel) ? prdata_sel : '0;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                end
            end
            DERR: begin
                state_d = IDLE;
                ready_d = 1'b1;
                error_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.PSEL    = psel;
    assign bus.PENABLE = (state_q == ACCESS);
    assign bus.PADDR   = paddr_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PSTRB   = pstrb_q;
    assign bus.ready   = ready_q;
    assign bus.error   = error_q;
    assign bus.rdata   = rdata_q;
endmodule

// File: tb/tb_apb_bridge_nslv.sv
// Randomized bench for apb_bridge_nslv: a transfer-level model predicts every
// cycle of each access (select, enable, held bus fields, completion pulse).
module tb_apb_bridge_nslv;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_SLV = 4;
    localparam int TIMEOUT = 16;

    logic PCLK;
    logic PRESET;

    apb_bridge_nslv_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV)) bus ();

    apb_bridge_nslv #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NUM_SLV(NUM_SLV),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus.master)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_addr;
    logic        m_write;
    logic [31:0] m_wdata;
    logic [3:0]  m_strb;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic [NUM_SLV-1:0] sel, input bit pen,
                           input bit rdy, input bit err, input logic [31:0] rd);
        chk({tag, ".psel"},    128'(bus.PSEL),    128'(sel));
        chk({tag, ".penable"}, 128'(bus.PENABLE), 128'(pen));
        chk({tag, ".ready"},   128'(bus.ready),   128'(rdy));
        chk({tag, ".error"},   128'(bus.error),   128'(err));
        chk({tag, ".rdata"},   128'(bus.rdata),   128'(rd));
        chk({tag, ".paddr"},   128'(bus.PADDR),   128'(m_addr));
        chk({tag, ".pwrite"},  128'(bus.PWRITE),  128'(m_write));
        chk({tag, ".pwdata"},  128'(bus.PWDATA),  128'(m_wdata));
        chk({tag, ".pstrb"},   128'(bus.PSTRB),   128'(m_strb));
    endtask

    // Random slave responses; the addressed slave gets the scripted PREADY/PSLVERR/PRDATA.
    task automatic drive_slaves(input int tgt, input bit rdy, input bit err, input logic [31:0] rd);
        for (int i = 0; i < NUM_SLV; i++) begin
            bus.PREADY[i]  = 1'($urandom);
            bus.PSLVERR[i] = 1'($urandom);
            bus.PRDATA[i*DATA_W +: DATA_W] = $urandom;
        end
        if (tgt >= 0) begin
            bus.PREADY[tgt] = rdy;
            if (rdy) begin
                bus.PSLVERR[tgt] = err;
                bus.PRDATA[tgt*DATA_W +: DATA_W] = rd;
            end
        end
    endtask

    // Spurious CPU requests while busy must be ignored.
    task automatic noise_cpu();
        bus.transfer = 1'($urandom);
        bus.write    = 1'($urandom);
        bus.addr     = {16'h1000, 4'($urandom_range(0, 15)), 12'($urandom)};
        bus.wdata    = $urandom;
        bus.strb     = 4'($urandom);
    endtask

    task automatic idle_cycle();
        bus.transfer = 1'b0;
        bus.addr     = $urandom;
        drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        step();
        chk_bus("idle", '0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Issues one request in the current cycle and checks every following cycle up to
    // and including the completion pulse; returns positioned in the ready cycle.
    task automatic do_xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] st, input int wt, input bit serr,
                           input logic [31:0] rd);
        bit                 hit;
        bit                 to;
        int                 idx;
        int                 nacc;
        logic [NUM_SLV-1:0] exp_sel;
        hit = (a[31:16] == 16'h1000) && (int'(a[15:12]) < NUM_SLV);
        idx = int'(a[15:12]);
        bus.transfer = 1'b1;
        bus.write    = wr;
        bus.addr     = a;
        bus.wdata    = wd;
        bus.strb     = st;
        drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        step();
        if (!hit) begin
            noise_cpu();
            drive_slaves(-1, 1'b0, 1'b0, 32'h0);
            chk_bus("derr", '0, 1'b0, 1'b0, 1'b0, 32'h0);
            step();
            bus.transfer = 1'b0;
            chk_bus("derr_done", '0, 1'b0, 1'b1, 1'b1, 32'h0);
        end else begin
            m_addr  = a;
            m_write = wr;
            m_wdata = wd;
            m_strb  = wr ? st : 4'h0;
            exp_sel = '0;
            exp_sel[idx] = 1'b1;
            to   = (TIMEOUT > 0) && (wt >= TIMEOUT);
            nacc = to ? TIMEOUT : wt + 1;
            noise_cpu();
            drive_slaves(-1, 1'b0, 1'b0, 32'h0);
            chk_bus("setup", exp_sel, 1'b0, 1'b0, 1'b0, 32'h0);
            step();
            for (int k = 0; k < nacc; k++) begin
                noise_cpu();
                drive_slaves(idx, !to && (k == wt), serr, rd);
                chk_bus("access", exp_sel, 1'b1, 1'b0, 1'b0, 32'h0);
                step();
            end
            bus.transfer = 1'b0;
            chk_bus("done", '0, 1'b0, 1'b1, to | serr, (!to && !wr && !serr) ? rd : 32'h0);
        end
        bus.transfer = 1'b0;
    endtask

    initial begin
        bit          wr;
        logic [31:0] a;
        int          wt;
        m_addr  = '0;
        m_write = 1'b0;
        m_wdata = '0;
        m_strb  = '0;
        PRESET       = 1'b0;
        bus.transfer = 1'b0;
        bus.write    = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.strb     = '0;
        drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        chk_bus("reset", '0, 1'b0, 1'b0, 1'b0, 32'h0);
        PRESET = 1'b1;

        // First request right after release, then back-to-back directed cases.
        do_xfer(1'b1, 32'h1000_2004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0);
        do_xfer(1'b0, 32'h1000_1000, 32'h5555_AAAA, 4'hF, 3, 1'b0, 32'h1234_5678);
        do_xfer(1'b0, 32'h2000_0000, 32'h0, 4'h0, 0, 1'b0, 32'h0);
        idle_cycle();
        do_xfer(1'b0, 32'h1000_0000, 32'h0BAD_F00D, 4'h3, 40, 1'b0, 32'hFFFF_FFFF);
        do_xfer(1'b0, 32'h1000_3010, 32'h0, 4'h0, 0, 1'b1, 32'hCAFE_0001);
        do_xfer(1'b0, 32'h1000_2FFC, 32'h0, 4'h0, TIMEOUT - 1, 1'b0, 32'hA5A5_5A5A);
        do_xfer(1'b1, 32'h1000_0010, 32'h0000_00FF, 4'h1, 2, 1'b1, 32'h0);
        do_xfer(1'b1, 32'h1000_4000, 32'h0, 4'hF, 0, 1'b0, 32'h0);
        idle_cycle();

        // Reset in the middle of ACCESS: select drops at once and no completion follows.
        bus.transfer = 1'b1;
        bus.write    = 1'b0;
        bus.addr     = 32'h1000_3008;
        bus.wdata    = 32'h7777_0000;
        bus.strb     = 4'hF;
        step();
        bus.transfer = 1'b0;
        m_addr  = 32'h1000_3008;
        m_write = 1'b0;
        m_wdata = 32'h7777_0000;
        m_strb  = 4'h0;
        drive_slaves(3, 1'b0, 1'b0, 32'h0);
        chk_bus("rst_setup", 4'b1000, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        drive_slaves(3, 1'b0, 1'b0, 32'h0);
        chk_bus("rst_access", 4'b1000, 1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        PRESET = 1'b0;
        #1;
        m_addr  = '0;
        m_write = 1'b0;
        m_wdata = '0;
        m_strb  = '0;
        chk_bus("rst_async", '0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive_slaves(3, 1'b1, 1'b0, 32'h1111_2222);
        step();
        chk_bus("rst_hold", '0, 1'b0, 1'b0, 1'b0, 32'h0);
        PRESET = 1'b1;
        do_xfer(1'b1, 32'h1000_0ABC, 32'h1357_9BDF, 4'h5, 1, 1'b0, 32'h0);

        for (int n = 0; n < 250; n++) begin
            wr = 1'($urandom);
            if ($urandom_range(0, 9) < 8) begin
                a = {16'h1000, 4'($urandom_range(0, 5)), 12'($urandom)};
            end else begin
                a = $urandom;
            end
            wt = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2)
                                             : $urandom_range(0, 4);
            do_xfer(wr, a, $urandom, 4'($urandom), wt, ($urandom_range(0, 7) == 0), $urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                idle_cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
